// File: rtl/edge_detector.sv
// Per-bit rising/falling edge detector with saturating event counters.
// Optional build macro EDGE_DETECTOR_SYNC_EN inserts a 2-flop input synchronizer per bit.
module edge_detector #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] A,
  input  logic             Clr,
  output logic [WIDTH-1:0] Rising_Edge,
  output logic [WIDTH-1:0] Falling_Edge,
  output logic             Any_Edge,
  output logic [CNT_W-1:0] Rise_Count,
  output logic [CNT_W-1:0] Fall_Count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] a_q;
  logic             any_rise;
  logic             any_fall;

`ifdef EDGE_DETECTOR_SYNC_EN
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= A;
      sync_q2 <= sync_q1;
    end
  end

  assign d = sync_q2;
`else
  assign d = A;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      a_q <= '0;
    end else begin
      a_q <= d;
    end
  end

  // Edges are combinational on d so there is no added latency; reset masks them.
  always_comb begin
    Rising_Edge  = '0;
    Falling_Edge = '0;
    if (!Rst) begin
      Rising_Edge  = d & ~a_q;
      Falling_Edge = ~d & a_q;
    end
  end

  assign any_rise = |Rising_Edge;
  assign any_fall = |Falling_Edge;
  assign Any_Edge = any_rise | any_fall;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      Rise_Count <= '0;
    end else if (any_rise && (Rise_Count != CNT_MAX)) begin
      Rise_Count <= Rise_Count + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || Clr) begin
      Fall_Count <= '0;
    end else if (any_fall && (Fall_Count != CNT_MAX)) begin
      Fall_Count <= Fall_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Scoreboard bench for edge_detector: three instances (1-bit, 4-bit, 2-bit-counter)
// share clock, reset and clear; expected results are queued per stimulus cycle.
module tb_edge_detector;

`ifdef EDGE_DETECTOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       Clk;
  logic       Rst;
  logic       Clr;
  logic       a1;
  logic [3:0] a4;
  logic       a_sat;

  logic       w1_rise, w1_fall, w1_any;
  logic [7:0] w1_rc, w1_fc;
  logic [3:0] w4_rise, w4_fall;
  logic       w4_any;
  logic [7:0] w4_rc, w4_fc;
  logic       sat_rise, sat_fall, sat_any;
  logic [1:0] sat_rc, sat_fc;

  edge_detector #(.WIDTH(1), .CNT_W(8)) u_w1 (
    .Clk(Clk), .Rst(Rst), .A(a1), .Clr(Clr),
    .Rising_Edge(w1_rise), .Falling_Edge(w1_fall), .Any_Edge(w1_any),
    .Rise_Count(w1_rc), .Fall_Count(w1_fc)
  );

  edge_detector #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .Clk(Clk), .Rst(Rst), .A(a4), .Clr(Clr),
    .Rising_Edge(w4_rise), .Falling_Edge(w4_fall), .Any_Edge(w4_any),
    .Rise_Count(w4_rc), .Fall_Count(w4_fc)
  );

  edge_detector #(.WIDTH(1), .CNT_W(2)) u_sat (
    .Clk(Clk), .Rst(Rst), .A(a_sat), .Clr(Clr),
    .Rising_Edge(sat_rise), .Falling_Edge(sat_fall), .Any_Edge(sat_any),
    .Rise_Count(sat_rc), .Fall_Count(sat_fc)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    logic       r1, f1;
    logic [7:0] rc1, fc1;
    logic [3:0] r4, f4;
    logic [7:0] rc4, fc4;
    logic       rs, fs;
    logic [1:0] rcs, fcs;
  } item_t;

  item_t sb[$];
  int checks;
  int errors;
  int cyc;

  // Reference model state, in stimulus time (before any synchronizer delay).
  logic       m_prev1;
  logic [3:0] m_prev4;
  logic       m_prevs;
  int m_rc1, m_fc1, m_rc4, m_fc4, m_rcs, m_fcs;

  function automatic int sat_inc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic next_cycle();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic check_out(input bit flushing);
    item_t it;
    if (sb.size() > LAT || (flushing && sb.size() > 0)) begin
      it = sb.pop_front();
      checks++;
      if ({w1_rise, w1_fall, w1_any, w1_rc, w1_fc} !== {it.r1, it.f1, it.r1 | it.f1, it.rc1, it.fc1}) begin
        errors++;
        $display("FAIL w1 stim_cyc=%0d got rise=%b fall=%b any=%b rc=%0d fc=%0d want rise=%b fall=%b rc=%0d fc=%0d",
                 it.cyc, w1_rise, w1_fall, w1_any, w1_rc, w1_fc, it.r1, it.f1, it.rc1, it.fc1);
      end
      checks++;
      if ({w4_rise, w4_fall, w4_any, w4_rc, w4_fc} !== {it.r4, it.f4, |{it.r4, it.f4}, it.rc4, it.fc4}) begin
        errors++;
        $display("FAIL w4 stim_cyc=%0d got rise=%b fall=%b any=%b rc=%0d fc=%0d want rise=%b fall=%b rc=%0d fc=%0d",
                 it.cyc, w4_rise, w4_fall, w4_any, w4_rc, w4_fc, it.r4, it.f4, it.rc4, it.fc4);
      end
      checks++;
      if ({sat_rise, sat_fall, sat_any, sat_rc, sat_fc} !== {it.rs, it.fs, it.rs | it.fs, it.rcs, it.fcs}) begin
        errors++;
        $display("FAIL sat stim_cyc=%0d got rise=%b fall=%b any=%b rc=%0d fc=%0d want rise=%b fall=%b rc=%0d fc=%0d",
                 it.cyc, sat_rise, sat_fall, sat_any, sat_rc, sat_fc, it.rs, it.fs, it.rcs, it.fcs);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue what the spec says it must produce, then compare.
  task automatic step(input logic rst, input logic v1, input logic [3:0] v4, input logic vs);
    item_t it;
    Rst   = rst;
    a1    = v1;
    a4    = v4;
    a_sat = vs;
    it.cyc = cyc;
    it.rc1 = 8'(m_rc1);
    it.fc1 = 8'(m_fc1);
    it.rc4 = 8'(m_rc4);
    it.fc4 = 8'(m_fc4);
    it.rcs = 2'(m_rcs);
    it.fcs = 2'(m_fcs);
    if (rst) begin
      it.r1 = 1'b0; it.f1 = 1'b0;
      it.r4 = '0;   it.f4 = '0;
      it.rs = 1'b0; it.fs = 1'b0;
      m_prev1 = 1'b0; m_prev4 = '0; m_prevs = 1'b0;
      m_rc1 = 0; m_fc1 = 0; m_rc4 = 0; m_fc4 = 0; m_rcs = 0; m_fcs = 0;
    end else begin
      it.r1 = v1 & ~m_prev1;
      it.f1 = ~v1 & m_prev1;
      it.r4 = v4 & ~m_prev4;
      it.f4 = ~v4 & m_prev4;
      it.rs = vs & ~m_prevs;
      it.fs = ~vs & m_prevs;
      if (it.r1)  m_rc1 = sat_inc(m_rc1, 255);
      if (it.f1)  m_fc1 = sat_inc(m_fc1, 255);
      if (|it.r4) m_rc4 = sat_inc(m_rc4, 255);
      if (|it.f4) m_fc4 = sat_inc(m_fc4, 255);
      if (it.rs)  m_rcs = sat_inc(m_rcs, 3);
      if (it.fs)  m_fcs = sat_inc(m_fcs, 3);
      m_prev1 = v1;
      m_prev4 = v4;
      m_prevs = vs;
    end
    sb.push_back(it);
    @(negedge Clk);
    check_out(1'b0);
    next_cycle();
  endtask

  task automatic flush();
    repeat (LAT) begin
      @(negedge Clk);
      check_out(1'b1);
      next_cycle();
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 4'hF, 1'b1);
    step(1'b1, 1'b1, 4'hF, 1'b1);
    step(1'b0, 1'b1, 4'hF, 1'b1);
    step(1'b0, 1'b1, 4'hF, 1'b1);
    step(1'b0, 1'b1, 4'hF, 1'b1);
    flush();
    @(negedge Clk);
    checks++;
    if (w1_rc !== 8'd1 || w4_rc !== 8'd1 || sat_rc !== 2'd1) begin
      errors++;
      $display("FAIL reset_release_count got w1=%0d w4=%0d sat=%0d want 1 1 1", w1_rc, w4_rc, sat_rc);
    end
    next_cycle();
  endtask

  task automatic test_sequence();
    logic seq [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int base_r, base_f;
    step(1'b0, 1'b0, 4'h0, 1'b1);
    flush();
    base_r = m_rc1;
    base_f = m_fc1;
    for (int i = 0; i < 6; i++) step(1'b0, seq[i], 4'h0, 1'b1);
    flush();
    @(negedge Clk);
    checks++;
    if (w1_rc !== 8'(base_r + 2) || w1_fc !== 8'(base_f + 1)) begin
      errors++;
      $display("FAIL seq_counts got rc=%0d fc=%0d want rc=%0d fc=%0d", w1_rc, w1_fc, base_r + 2, base_f + 1);
    end
    next_cycle();
  endtask

  task automatic test_width4();
    int base_r, base_f;
    base_r = m_rc4;
    base_f = m_fc4;
    step(1'b0, 1'b1, 4'b0101, 1'b1);
    step(1'b0, 1'b1, 4'b1010, 1'b1);
    flush();
    @(negedge Clk);
    checks++;
    if (w4_rc !== 8'(base_r + 2) || w4_fc !== 8'(base_f + 1)) begin
      errors++;
      $display("FAIL w4_counts got rc=%0d fc=%0d want rc=%0d fc=%0d", w4_rc, w4_fc, base_r + 2, base_f + 1);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic v;
    v = a_sat;
    for (int i = 0; i < 10; i++) begin
      v = ~v;
      step(1'b0, v, a4, v);
    end
    flush();
    @(negedge Clk);
    checks++;
    if (sat_rc !== 2'd3 || sat_fc !== 2'd3) begin
      errors++;
      $display("FAIL saturate got rc=%0d fc=%0d want 3 3", sat_rc, sat_fc);
    end
    next_cycle();
  endtask

  task automatic test_clear();
    step(1'b0, 1'b0, a4, 1'b0);
    step(1'b0, 1'b0, a4, 1'b0);
    flush();
    a1    = 1'b1;
    a_sat = 1'b1;
    repeat (LAT) next_cycle();
    Clr = 1'b1;
    @(negedge Clk);
    checks++;
    if (w1_rise !== 1'b1 || sat_rise !== 1'b1 || sat_rc !== 2'd3) begin
      errors++;
      $display("FAIL clr_cycle got w1_rise=%b sat_rise=%b sat_rc=%0d want 1 1 3", w1_rise, sat_rise, sat_rc);
    end
    next_cycle();
    Clr = 1'b0;
    @(negedge Clk);
    checks++;
    if (w1_rc !== 8'd0 || w1_fc !== 8'd0 || sat_rc !== 2'd0 || sat_fc !== 2'd0 || w4_rc !== 8'd0) begin
      errors++;
      $display("FAIL clr_result got w1 rc=%0d fc=%0d sat rc=%0d fc=%0d w4 rc=%0d want all 0",
               w1_rc, w1_fc, sat_rc, sat_fc, w4_rc);
    end
    checks++;
    if (w1_rise !== 1'b0 || w1_fall !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_repulse got rise=%b fall=%b want 0 0", w1_rise, w1_fall);
    end
    m_prev1 = 1'b1;
    m_prevs = 1'b1;
    m_rc1 = 0; m_fc1 = 0; m_rc4 = 0; m_fc4 = 0; m_rcs = 0; m_fcs = 0;
    next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    flush();
  endtask

  task automatic test_reset_mid_pulse();
    step(1'b0, 1'b0, a4, 1'b0);
    step(1'b0, 1'b0, a4, 1'b0);
    flush();
    a1 = 1'b1;
    repeat (LAT) next_cycle();
    Rst = 1'b1;
    @(negedge Clk);
    checks++;
    if (w1_rise !== 1'b0 || w1_any !== 1'b0) begin
      errors++;
      $display("FAIL rst_suppress got rise=%b any=%b want 0 0", w1_rise, w1_any);
    end
    next_cycle();
    Rst = 1'b0;
    repeat (LAT) next_cycle();
    @(negedge Clk);
    checks++;
    if (w1_rise !== 1'b1 || w1_rc !== 8'd0) begin
      errors++;
      $display("FAIL rst_rerise got rise=%b rc=%0d want 1 0", w1_rise, w1_rc);
    end
    next_cycle();
    @(negedge Clk);
    checks++;
    if (w1_rise !== 1'b0 || w1_rc !== 8'd1) begin
      errors++;
      $display("FAIL rst_rerise_after got rise=%b rc=%0d want 0 1", w1_rise, w1_rc);
    end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    Rst    = 1'b1;
    Clr    = 1'b0;
    a1     = 1'b0;
    a4     = 4'h0;
    a_sat  = 1'b0;
    m_prev1 = 1'b0; m_prev4 = '0; m_prevs = 1'b0;
    m_rc1 = 0; m_fc1 = 0; m_rc4 = 0; m_fc4 = 0; m_rcs = 0; m_fcs = 0;
    next_cycle();
    test_reset();
    test_sequence();
    test_width4();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_detector.md
EDGE_DETECTOR -- requirements
Module: edge_detector

Interface
REQ-001 Parameter WIDTH, default 1; number of independent input bits monitored (legal 1..32).
REQ-002 Parameter CNT_W, default 8; width of each event counter (legal 1..16).
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset, sampled on rising Clk.
REQ-005 A  input  WIDTH  monitored signal vector, one edge detector per bit.
REQ-006 Clr  input  1  synchronous clear of both event counters.
REQ-007 Rising_Edge  output  WIDTH  per-bit one-cycle pulse on a 0->1 transition.
REQ-008 Falling_Edge  output  WIDTH  per-bit one-cycle pulse on a 1->0 transition.
REQ-009 Any_Edge  output  1  OR-reduction of all Rising_Edge and Falling_Edge bits.
REQ-010 Rise_Count  output  CNT_W  saturating count of cycles with any Rising_Edge bit set.
REQ-011 Fall_Count  output  CNT_W  saturating count of cycles with any Falling_Edge bit set.

Function
REQ-012 Block SHALL hold a WIDTH-bit register A_q, loaded every Clk with the detection input D (D = A, or the synchronizer output per REQ-024).
REQ-013 Rising_Edge[i] SHALL equal D[i] AND NOT A_q[i], combinationally (same cycle D changes, zero added latency).
REQ-014 Falling_Edge[i] SHALL equal NOT D[i] AND A_q[i], combinationally.
REQ-015 A level held N cycles SHALL produce exactly one pulse, one cycle wide; a D toggling every cycle SHALL pulse every cycle, alternating rising/falling.
REQ-016 Rising_Edge[i] and Falling_Edge[i] SHALL never be asserted together; different bits SHALL be independent and may pulse in the same cycle.
REQ-017 Rise_Count SHALL increment by 1 at each Clk where |Rising_Edge is 1 (multiple bits in one cycle count once); Fall_Count likewise for |Falling_Edge.
REQ-018 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 Clr=1 SHALL set both counters to 0 at next Clk; Clr has priority over a simultaneous increment; edge outputs and A_q unaffected by Clr.

Reset
REQ-020 While Rst=1 at a Clk edge, A_q, all synchronizer stages and both counters SHALL load 0.
REQ-021 While Rst=1, Rising_Edge, Falling_Edge and Any_Edge SHALL be forced to 0 combinationally; counters SHALL not increment.
REQ-022 First cycle after Rst deasserts, A_q=0, so a D bit already at 1 SHALL produce one Rising_Edge pulse and count once.
REQ-023 Rst asserted mid-pulse SHALL suppress the pulse in that cycle; Rst has priority over Clr.

Configuration
REQ-024 Macro EDGE_DETECTOR_SYNC_EN: when defined, A SHALL pass through a 2-flop per-bit synchronizer (reset to 0) and D is the second stage output, so pulses appear 2 Clk cycles after A changes; when undefined, D = A directly with no synchronizer flops and REQ-013 timing.

Verification
REQ-025 Rst=1 two cycles with A=1 -> all edge outputs 0, counters 0; release Rst -> Rising_Edge=1 for exactly one cycle, Rise_Count=1.
REQ-026 WIDTH=1, A sequence 0,1,1,0,0,1 (one value per cycle) -> Rising_Edge 0,1,0,0,0,1; Falling_Edge 0,0,0,1,0,0; Rise_Count=2, Fall_Count=1.
REQ-027 WIDTH=4, A 0000->0101->1010 -> cycle 2 Rising=0101; cycle 3 Rising=1010 and Falling=0101 together, Any_Edge=1, each counter +1 only.
REQ-028 CNT_W=2, A toggled every cycle for 10 cycles -> Rise_Count and Fall_Count stop at 3; assert Clr during a rising edge -> Rise_Count=0 next cycle.
REQ-029 EDGE_DETECTOR_SYNC_EN defined, A 0->1 at cycle k -> Rising_Edge pulses at cycle k+2 only; undefined -> at cycle k.
REQ-030 Random 1-bit A for 1000 cycles -> pulses match a reference model (D XOR previous D) every cycle; counters equal pulse totals (below saturation).
